// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data-memory arbiter with burst limit
// Ports 0/1 share one combinational data memory; completions are registered one cycle later.
module dmem_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t      state, state_next;
  logic        last_port, last_port_next;
  logic [3:0]  burst_cnt, burst_cnt_next, burst_inc;
  logic        xfer0, xfer1, xfer, illegal, sel_we;
  logic [31:0] sel_addr, sel_wdata, rd_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_port <= 1'b1;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      last_port <= last_port_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // burst_inc is the count after this cycle's transfer; handoff compares against it
  always_comb begin
    state_next     = state;
    last_port_next = last_port;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_next = last_port ? GNT0 : GNT1;
        else if (req0)     state_next = GNT0;
        else if (req1)     state_next = GNT1;
      end
      GNT0: begin
        if (req1) begin
          if (!req0 || burst_inc == BURST_LIM) state_next = GNT1;
        end else if (!req0) begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        if (req0) begin
          if (!req1 || burst_inc == BURST_LIM) state_next = GNT0;
        end else if (!req1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == GNT0 && state != GNT0) last_port_next = 1'b0;
    if (state_next == GNT1 && state != GNT1) last_port_next = 1'b1;
    burst_cnt_next = (state_next != state) ? 4'd0 : burst_inc;
  end

  always_comb begin
    gnt0      = rst_n && (state == GNT0);
    gnt1      = rst_n && (state == GNT1);
    xfer0     = gnt0 && req0;
    xfer1     = gnt1 && req1;
    xfer      = xfer0 || xfer1;
    sel_addr  = xfer1 ? addr1 : addr0;
    sel_wdata = xfer1 ? wdata1 : wdata0;
    sel_we    = xfer1 ? we1 : we0;
    illegal   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> ADDR_BITS) != 32'd0);
    burst_inc = (xfer && burst_cnt != BURST_LIM) ? burst_cnt + 4'd1 : burst_cnt;
    mem_we    = xfer && sel_we && !illegal;
    mem_addr  = xfer ? sel_addr : 32'd0;
    mem_wdata = xfer ? sel_wdata : 32'd0;
    rd_value  = (!illegal && !sel_we) ? mem_rdata : 32'd0;
  end

  // Completion registers hold data/error until the port's next transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= 32'd0;
      rdata1  <= 32'd0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      rvalid0 <= xfer0;
      rvalid1 <= xfer1;
      if (xfer0) begin
        rdata0 <= rd_value;
        err0   <= illegal;
      end
      if (xfer1) begin
        rdata1 <= rd_value;
        err1   <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Directed scenarios, a reference arbiter/memory model and a per-cycle compare process.
module tb_dmem_arbiter;

  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  int          m_owner = -1;
  int          m_run = 0;
  int          m_last = 1;
  logic        m_rv [2];
  logic        m_er [2];
  logic [31:0] m_rd [2];

  logic rec = 1'b0;
  int   recq[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.BURST_MAX(BURST_MAX), .ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic logic rq(int p);
    return (p == 0) ? req0 : req1;
  endfunction
  function automatic logic wr(int p);
    return (p == 0) ? we0 : we1;
  endfunction
  function automatic logic [31:0] ad(int p);
    return (p == 0) ? addr0 : addr1;
  endfunction
  function automatic logic [31:0] wd(int p);
    return (p == 0) ? wdata0 : wdata1;
  endfunction
  function automatic logic bad_addr(logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  always @(posedge clk) begin : model
    int o, nx;
    logic [31:0] a;
    if (!rst_n) begin
      m_owner = -1; m_run = 0; m_last = 1;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_er[0] = 1'b0; m_er[1] = 1'b0;
      m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    end else begin
      o = m_owner;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (o >= 0 && rq(o)) begin
        a = ad(o);
        m_rv[o] = 1'b1;
        m_er[o] = bad_addr(a);
        m_rd[o] = (!bad_addr(a) && !wr(o)) ? ref_mem[a / 4] : 32'd0;
        if (!bad_addr(a) && wr(o)) ref_mem[a / 4] = wd(o);
        if (m_run < BURST_MAX) m_run = m_run + 1;
      end
      if (o < 0) begin
        if (req0 && req1) nx = 1 - m_last;
        else if (req0)    nx = 0;
        else if (req1)    nx = 1;
        else              nx = -1;
      end else if (rq(1 - o)) begin
        nx = (!rq(o) || m_run == BURST_MAX) ? 1 - o : o;
      end else begin
        nx = rq(o) ? o : -1;
      end
      if (nx != o) begin
        m_run = 0;
        if (nx >= 0) m_last = nx;
      end
      m_owner = nx;
    end
  end

  always @(negedge clk) begin : compare
    logic e_g0, e_g1, e_x;
    int   p;
    e_g0 = rst_n && m_owner == 0;
    e_g1 = rst_n && m_owner == 1;
    p    = e_g1 ? 1 : 0;
    e_x  = (e_g0 && req0) || (e_g1 && req1);
    chk("gnt0", 32'(gnt0), 32'(e_g0));
    chk("gnt1", 32'(gnt1), 32'(e_g1));
    chk("mem_we", 32'(mem_we), 32'(e_x && wr(p) && !bad_addr(ad(p))));
    chk("mem_addr", mem_addr, e_x ? ad(p) : 32'd0);
    chk("mem_wdata", mem_wdata, e_x ? wd(p) : 32'd0);
    chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
    chk("err0", 32'(err0), 32'(m_er[0]));
    chk("err1", 32'(err1), 32'(m_er[1]));
    if (rec) recq.push_back((gnt0 && req0) ? 1 : (gnt1 && req1) ? 2 : 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_b [12];
    int n0;
    exp_b = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1};
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    m_er[0] = 1'b0; m_er[1] = 1'b0;
    m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    step(); step(); step();
    rst_n = 1'b1;
    #1;
    chk("reset_gnt0", 32'(gnt0), 32'd0);
    chk("reset_rvalid0", 32'(rvalid0), 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_err0", 32'(err0), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);

    // write 0xDEADBEEF to 0x10, then read it back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
    step();
    chk("wr_gnt0", 32'(gnt0), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    step();
    chk("wr_rvalid0", 32'(rvalid0), 32'd1);
    chk("wr_err0", 32'(err0), 32'd0);
    req0 = 1'b0;
    step();
    chk("wr_rvalid0_pulse", 32'(rvalid0), 32'd0);
    req0 = 1'b1; we0 = 1'b0;
    step(); step();
    chk("rd_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    req0 = 1'b0;
    step(); step();

    // both ports requesting from reset
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h40; addr1 = 32'h44;
    step(); step();
    rst_n = 1'b1; rec = 1'b1;
    repeat (12) step();
    rec = 1'b0;
    chk("burst_len", 32'(recq.size()), 32'd12);
    for (int i = 0; i < 12 && i < recq.size(); i++) chk($sformatf("burst_seq%0d", i), 32'(recq[i]), 32'(exp_b[i]));
    recq.delete();
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // illegal addresses on port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h402;
    step(); step();
    chk("ill_rvalid1_a", 32'(rvalid1), 32'd1);
    chk("ill_err1_a", 32'(err1), 32'd1);
    chk("ill_rdata1_a", rdata1, 32'd0);
    addr1 = 32'h400;
    step();
    chk("ill_err1_b", 32'(err1), 32'd1);
    chk("ill_rdata1_b", rdata1, 32'd0);
    addr1 = 32'h404; we1 = 1'b1; wdata1 = 32'h1234_5678;
    #1;
    chk("ill_mem_we", 32'(mem_we), 32'd0);
    chk("ill_mem_addr", mem_addr, 32'h404);
    step();
    chk("ill_err1_c", 32'(err1), 32'd1);
    req1 = 1'b0; we1 = 1'b0;
    step(); step();

    // single port held: back-to-back transfers, then port 1 joins
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    step();
    rst_n = 1'b1; rec = 1'b1;
    repeat (10) step();
    rec = 1'b0;
    n0 = 0;
    foreach (recq[i]) if (recq[i] == 1) n0++;
    chk("solo_first_idle", 32'(recq.size() > 0 ? recq[0] : -1), 32'd0);
    chk("solo_xfers", 32'(n0), 32'd9);
    recq.delete();
    req1 = 1'b1; addr1 = 32'h20;
    step(); step(); step();
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // reset lands on a port-1 write to 0x20
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hCAFE_F00D;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    step();
    rst_n = 1'b1; req1 = 1'b0; we1 = 1'b0;
    #1;
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    step();
    chk("rst_rvalid1_after", 32'(rvalid1), 32'd0);
    step();

    chk("mem_word_0x20", dmem[8], 32'h0808_0808);
    chk("mem_word_0x04", dmem[1], 32'h0101_0101);
    chk("mem_word_0x10", dmem[4], 32'hDEAD_BEEF);
    n0 = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) n0++;
    chk("mem_vs_model", 32'(n0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 4, the maximum number of consecutive transfers granted to one port while the other port is requesting (legal range 1..15).
REQ-002 The block SHALL have parameter ADDR_BITS, default 10, the number of low byte-address bits that decode into the 256-word data memory.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req0, req1  in  1 each  access request, port 0 (CPU load/store) and port 1 (loader/debug).
REQ-006 we0, we1  in  1 each  1 = write, 0 = read.
REQ-007 addr0, addr1  in  32 each  byte address.
REQ-008 wdata0, wdata1  in  32 each  write data.
REQ-009 gnt0, gnt1  out  1 each  grant; transfer occurs in any cycle where reqX && gntX.
REQ-010 rvalid0, rvalid1  out  1 each  one-cycle completion pulse, registered.
REQ-011 rdata0, rdata1  out  32 each  read data, registered; valid with rvalidX.
REQ-012 err0, err1  out  1 each  error flag, valid with rvalidX.
REQ-013 mem_we  out  1  drives data memory MemWrite.
REQ-014 mem_addr, mem_wdata  out  32 each  drive data memory address and write_data.
REQ-015 mem_rdata  in  32  combinational read_data from data memory.

Function
REQ-016 FSM states SHALL be IDLE, GNT0, GNT1; gnt0 = (state==GNT0), gnt1 = (state==GNT1), both combinational from state.
REQ-017 IDLE: no requests -> IDLE; one request -> that port's GNT; both -> port != last_port; last_port updates to the winner.
REQ-018 A transfer SHALL be accepted only in a GNTx cycle with reqX=1; requests in IDLE are never transferred in that cycle (arbitration latency 1 cycle).
REQ-019 During a transfer, mem_addr/mem_wdata SHALL equal the granted port's addr/wdata combinationally; outside a transfer they SHALL be 0 and mem_we 0.
REQ-020 mem_we SHALL be weX for a legal transfer; a write commits at the posedge ending the transfer cycle.
REQ-021 A transfer SHALL be illegal if addrX[1:0] != 0 or addrX[31:ADDR_BITS] != 0; illegal transfers force mem_we=0.
REQ-022 The cycle after a transfer, rvalidX SHALL be 1 for exactly one cycle; rdataX = mem_rdata sampled at the transfer edge for a legal read, 0 for writes and illegal transfers; errX = 1 iff illegal.
REQ-023 rdataX and errX SHALL hold their value until the next rvalidX pulse.
REQ-024 A 4-bit burst counter SHALL reset to 0 on every grant change and increment on each transfer, saturating at BURST_MAX.
REQ-025 GNTx with other port requesting: switch directly to the other GNT (no IDLE) when reqX=0 or the counter value after this cycle's transfer equals BURST_MAX; update last_port.
REQ-026 GNTx with other port idle: stay while reqX=1; go to IDLE when reqX=0.
REQ-027 Back-to-back transfers SHALL be sustained at one per cycle by a single port.
REQ-028 The grant in a cycle SHALL never change combinationally mid-cycle; a dropped reqX simply produces no transfer that cycle.

Reset
REQ-029 While rst_n=0 at posedge: state=IDLE, last_port=1 (port 0 wins first tie), counter=0, rvalid0/1=0, err0/1=0, rdata0/1=0.
REQ-030 While rst_n=0, gnt0/1, mem_we, mem_addr, mem_wdata SHALL be 0 regardless of state, so a write pending in that cycle is dropped.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; no rvalid pulse follows the reset cycle.

Verification
REQ-032 Reset, req0 write addr 0x10 data 0xDEADBEEF -> gnt0 next cycle, mem_we=1 one cycle, rvalid0 next with err0=0; later read 0x10 -> rdata0=0xDEADBEEF.
REQ-033 req0, req1 both held from reset for 12 cycles, BURST_MAX=4 -> grants 1 idle cycle, then 4 port-0, 4 port-1, 3 port-0 transfers, no gap at handoffs.
REQ-034 req1 read addr 0x402 then 0x400 -> err1=1, rdata1=0, mem_we=0 for each; memory unchanged.
REQ-035 Only req0 held 10 cycles -> 9 consecutive transfers after the IDLE cycle, counter saturated, gnt0 never drops.
REQ-036 rst_n low during GNT1 write to 0x20 -> mem_we=0 that cycle, state IDLE after, no rvalid1, word 0x20 unchanged.
